// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared channel FSM states, default end-of-test tokens and channel-tag width helper.
package sim_monitor_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} ch_state_e;
  localparam logic [7:0] DEF_PASS_CHAR = 8'h06;
  localparam logic [7:0] DEF_FAIL_CHAR = 8'h15;
  function automatic int CH_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sim_uart_monitor_rx_chan.sv
// uart_rx_chan: one UART receive lane (sync, frame FSM, one-deep pending byte).
// SIM_UART_PARITY_EN adds an even-parity bit checked between data and stop.
module uart_rx_chan
  import sim_monitor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rxd_i,
  input  logic       ack_i,
  output logic       pend_o,
  output logic [7:0] data_o,
  output logic       ferr_o,
  output logic       ovf_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef SIM_UART_PARITY_EN
  localparam ch_state_e AFTER_DATA = PARITY;
`else
  localparam ch_state_e AFTER_DATA = STOP;
`endif
  logic [1:0] sync_q;
  ch_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, data_q;
  logic pend_q, ferr_q, ovf_q, rx;
  assign rx = sync_q[1];
  assign pend_o = pend_q;
  assign data_o = data_q;
  assign ferr_o = ferr_q;
  assign ovf_o = ovf_q;
  // IDLE is only ever entered with the line high, so a low level there is a falling edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      pend_q <= 1'b0;
      ferr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd_i};
      ovf_q <= 1'b0;
      cnt_q <= cnt_q + CW'(1);
      if (ack_i) pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rx) state_q <= START;
        end
        START: if (cnt_q == MID) begin
          cnt_q <= '0;
          state_q <= rx ? IDLE : DATA;
        end
        DATA: if (cnt_q == LAST) begin
          cnt_q <= '0;
          shift_q <= {rx, shift_q[7:1]};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= AFTER_DATA;
        end
`ifdef SIM_UART_PARITY_EN
        PARITY: if (cnt_q == LAST) begin
          cnt_q <= '0;
          if (rx == ^shift_q) state_q <= STOP;
          else begin
            ferr_q <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
`endif
        STOP: if (cnt_q == LAST) begin
          if (rx) begin
            pend_q <= 1'b1;
            data_q <= shift_q;
            ovf_q <= pend_q & ~ack_i;
            state_q <= IDLE;
          end else begin
            ferr_q <= 1'b1;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: if (rx) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sim_uart_monitor.sv
// sim_uart_monitor: multi-channel UART sniffer merging bytes into a tagged FWFT FIFO with PASS/FAIL detect.
// Define SIM_UART_PARITY_EN for even-parity frames (8E1) instead of 8N1.
module sim_uart_monitor
  import sim_monitor_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH = 16,
  parameter logic [7:0] PASS_CHAR = DEF_PASS_CHAR,
  parameter logic [7:0] FAIL_CHAR = DEF_FAIL_CHAR,
  localparam int CW = CH_W(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] RXD,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [7:0]        OUT_DATA,
  output logic [CW-1:0]     OUT_CH,
  output logic [NUM_CH-1:0] FRAME_ERR,
  output logic              OVERFLOW,
  output logic              DONE,
  output logic              PASS
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [NUM_CH-1:0] pend, ack, ovf;
  logic [7:0] ch_data [NUM_CH];
  logic gnt_v, pop, push, full, ovf_q, done_q, pass_q;
  logic [CW-1:0] gnt_ch, ptr_q;
  logic [7:0] gnt_data;
  logic [8+CW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    uart_rx_chan #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_chan (
      .CLK(CLK), .RST(RST), .rxd_i(RXD[i]), .ack_i(ack[i]),
      .pend_o(pend[i]), .data_o(ch_data[i]), .ferr_o(FRAME_ERR[i]), .ovf_o(ovf[i])
    );
  end
  // Scan downward so the pending channel closest after ptr_q wins
  always_comb begin
    gnt_v = 1'b0;
    gnt_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (pend[(int'(ptr_q) + k) % NUM_CH]) begin
        gnt_v = 1'b1;
        gnt_ch = CW'((int'(ptr_q) + k) % NUM_CH);
      end
  end
  assign gnt_data = ch_data[gnt_ch];
  assign ack = gnt_v ? (NUM_CH'(1) << gnt_ch) : '0;
  assign OUT_VALID = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign pop = OUT_VALID & OUT_READY;
  assign push = gnt_v & (~full | pop);
  assign {OUT_CH, OUT_DATA} = OUT_VALID ? mem_q[rd_q] : '0;
  assign OVERFLOW = ovf_q;
  assign DONE = done_q;
  assign PASS = pass_q;
  always_ff @(posedge CLK)
    if (push) mem_q[wr_q] <= {gnt_ch, gnt_data};
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (gnt_v) ptr_q <= (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CW'(1);
      if ((gnt_v & ~push) | (|ovf)) ovf_q <= 1'b1;
      if (gnt_v & ~done_q & (gnt_data == PASS_CHAR | gnt_data == FAIL_CHAR)) begin
        done_q <= 1'b1;
        pass_q <= gnt_data == PASS_CHAR;
      end
    end
  end
endmodule
